// File: rtl/cu_channel_responder_if.sv
// Parallel-channel tag and bus bundle between a channel and a control unit.
//
// Channel -> CU : bus_out[7:0], bus_out_parity, operational_out, select_out,
//                 hold_out, address_out, command_out, service_out
// CU -> Channel : bus_in[7:0], bus_in_parity, operational_in, select_in,
//                 address_in, status_in, service_in, request_in
//
// modport master : channel side (drives the *_out signals)
// modport slave  : control-unit side (drives the *_in signals)
interface cu_channel_responder_if;
    logic [7:0] bus_out;
    logic       bus_out_parity;
    logic       operational_out;
    logic       select_out;
    logic       hold_out;
    logic       address_out;
    logic       command_out;
    logic       service_out;

    logic [7:0] bus_in;
    logic       bus_in_parity;
    logic       operational_in;
    logic       select_in;
    logic       address_in;
    logic       status_in;
    logic       service_in;
    logic       request_in;

    modport master (
        output bus_out, bus_out_parity, operational_out, select_out, hold_out,
               address_out, command_out, service_out,
        input  bus_in, bus_in_parity, operational_in, select_in, address_in,
               status_in, service_in, request_in
    );

    modport slave (
        input  bus_out, bus_out_parity, operational_out, select_out, hold_out,
               address_out, command_out, service_out,
        output bus_in, bus_in_parity, operational_in, select_in, address_in,
               status_in, service_in, request_in
    );
endinterface

// File: rtl/cu_channel_responder.sv
// Control-unit-side endpoint of the parallel channel. Answers initial
// selection, takes the command byte, presents initial status, moves data
// bytes in either direction and presents ending status, then disconnects.
//
// Parameters:
//   DEV_ADDR    - device address answered on bus_out
//   PASS_SELECT - 1: propagate select_out to select_in when not addressed
// Ports:
//   clk, reset_n (async, active low), enable
//   ch           - channel tags/bus (cu_channel_responder_if.slave)
//   cmd/cmd_valid            - latched command byte, one-cycle pulse
//   status/status_valid      - initial or ending status from the device
//   rd_data/rd_valid/rd_ready- read-direction byte, rd_ready pulses when taken
//   wr_req/wr_data/wr_valid  - write-direction request, received byte + pulse
//   end_req                  - device ready to present ending status
//   stop                     - pulse: channel answered service_in with command_out
//   busy                     - responder not idle
//   parity_err               - sticky bus_out parity error
// Build option:
//   CU_PARITY_CHECK_EN - check bus_out_parity on address, command and write
//                        bytes; without it parity_err stays 0.
module cu_channel_responder #(
    parameter logic [7:0] DEV_ADDR    = 8'h00,
    parameter bit         PASS_SELECT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    cu_channel_responder_if.slave   ch,
    output logic [7:0]              cmd,
    output logic                    cmd_valid,
    input  logic [7:0]              status,
    input  logic                    status_valid,
    input  logic [7:0]              rd_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic                    wr_req,
    output logic [7:0]              wr_data,
    output logic                    wr_valid,
    input  logic                    end_req,
    output logic                    stop,
    output logic                    busy,
    output logic                    parity_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_PASS, S_ADDR, S_CMDW, S_ISTAT,
        S_OUTW, S_DATA, S_SVC, S_ESTAT, S_DISC
    } state_t;

    state_t     state_q, after_q;
    logic [7:0] bus_in_q;
    logic       op_in_q, sel_in_q, addr_in_q, stat_in_q, svc_in_q, req_in_q;
    logic       live_q;
    logic [7:0] cmd_q, wr_data_q;
    logic       cmd_valid_q, rd_ready_q, wr_valid_q, stop_q;
    logic       svc_write_q;
    logic       par_err_q;

    logic       par_ok;
    logic       addr_hit;
    logic       sel_req;
    logic       unused_hold;

`ifdef CU_PARITY_CHECK_EN
    assign par_ok = (ch.bus_out_parity == ~^ch.bus_out);
`else
    logic unused_parity;
    assign par_ok        = 1'b1;
    assign unused_parity = ch.bus_out_parity;
`endif

    assign unused_hold = ch.hold_out;
    assign sel_req     = ch.operational_out & ch.address_out & ch.select_out;
    assign addr_hit    = (ch.bus_out == DEV_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            after_q     <= S_IDLE;
            bus_in_q    <= '0;
            op_in_q     <= 1'b0;
            sel_in_q    <= 1'b0;
            addr_in_q   <= 1'b0;
            stat_in_q   <= 1'b0;
            svc_in_q    <= 1'b0;
            req_in_q    <= 1'b0;
            live_q      <= 1'b0;
            cmd_q       <= '0;
            wr_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            rd_ready_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            stop_q      <= 1'b0;
            svc_write_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            rd_ready_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            stop_q      <= 1'b0;
            req_in_q    <= 1'b0;

            if (!enable || !ch.operational_out) begin
                // Disable and channel abort share the teardown; only a
                // disabled unit keeps the select chain alive.
                state_q   <= S_IDLE;
                bus_in_q  <= '0;
                op_in_q   <= 1'b0;
                addr_in_q <= 1'b0;
                stat_in_q <= 1'b0;
                svc_in_q  <= 1'b0;
                sel_in_q  <= ~enable & ch.select_out;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sel_in_q <= 1'b0;
                        if (sel_req) begin
                            if (addr_hit && par_ok) begin
                                op_in_q   <= 1'b1;
                                addr_in_q <= 1'b1;
                                bus_in_q  <= DEV_ADDR;
                                par_err_q <= 1'b0;
                                state_q   <= S_ADDR;
                            end else begin
                                // Matching address with bad parity lands here.
                                if (addr_hit) par_err_q <= 1'b1;
                                sel_in_q <= PASS_SELECT;
                                state_q  <= S_PASS;
                            end
                        end else begin
                            req_in_q <= end_req | rd_valid;
                        end
                    end
                    S_PASS: begin
                        sel_in_q <= PASS_SELECT & ch.select_out;
                        if (!ch.select_out) state_q <= S_IDLE;
                    end
                    S_ADDR: begin
                        if (ch.command_out) begin
                            cmd_q       <= ch.bus_out;
                            cmd_valid_q <= 1'b1;
                            addr_in_q   <= 1'b0;
                            bus_in_q    <= '0;
                            if (!par_ok) par_err_q <= 1'b1;
                            state_q     <= S_CMDW;
                        end
                    end
                    S_CMDW: begin
                        if (!ch.command_out && status_valid) begin
                            bus_in_q  <= status;
                            stat_in_q <= 1'b1;
                            state_q   <= S_ISTAT;
                        end
                    end
                    S_ISTAT: begin
                        // command_out wins over service_out (stacked status).
                        if (ch.command_out || ch.service_out) begin
                            stat_in_q <= 1'b0;
                            bus_in_q  <= '0;
                            if (ch.command_out || bus_in_q[3]) after_q <= S_DISC;
                            else                               after_q <= S_DATA;
                            state_q   <= S_OUTW;
                        end
                    end
                    S_OUTW: begin
                        if (!ch.service_out && !ch.command_out) state_q <= after_q;
                    end
                    S_DATA: begin
                        if (end_req) begin
                            if (status_valid) begin
                                bus_in_q  <= status;
                                stat_in_q <= 1'b1;
                                state_q   <= S_ESTAT;
                            end
                        end else if (rd_valid) begin
                            bus_in_q    <= rd_data;
                            svc_in_q    <= 1'b1;
                            rd_ready_q  <= 1'b1;
                            svc_write_q <= 1'b0;
                            state_q     <= S_SVC;
                        end else if (wr_req) begin
                            svc_in_q    <= 1'b1;
                            svc_write_q <= 1'b1;
                            state_q     <= S_SVC;
                        end
                    end
                    S_SVC: begin
                        if (ch.command_out || ch.service_out) begin
                            if (ch.command_out) begin
                                stop_q <= 1'b1;
                            end else if (svc_write_q) begin
                                wr_data_q  <= ch.bus_out;
                                wr_valid_q <= 1'b1;
                                if (!par_ok) par_err_q <= 1'b1;
                            end
                            svc_in_q <= 1'b0;
                            bus_in_q <= '0;
                            after_q  <= S_DATA;
                            state_q  <= S_OUTW;
                        end
                    end
                    S_ESTAT: begin
                        if (ch.command_out || ch.service_out) begin
                            stat_in_q <= 1'b0;
                            bus_in_q  <= '0;
                            after_q   <= S_DISC;
                            state_q   <= S_OUTW;
                        end
                    end
                    S_DISC: begin
                        op_in_q  <= 1'b0;
                        bus_in_q <= '0;
                        state_q  <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Parity is forced low only while held in reset so every output reads 0.
    assign ch.bus_in_parity  = live_q & ~^bus_in_q;
    assign ch.bus_in         = bus_in_q;
    assign ch.operational_in = op_in_q;
    assign ch.select_in      = sel_in_q;
    assign ch.address_in     = addr_in_q;
    assign ch.status_in      = stat_in_q;
    assign ch.service_in     = svc_in_q;
    assign ch.request_in     = req_in_q;

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign rd_ready   = rd_ready_q;
    assign wr_data    = wr_data_q;
    assign wr_valid   = wr_valid_q;
    assign stop       = stop_q;
    assign busy       = (state_q != S_IDLE);
    assign parity_err = par_err_q;

endmodule

// File: tb/tb_cu_channel_responder.sv
module tb_cu_channel_responder;
    localparam logic [7:0] DEV = 8'h0E;
`ifdef CU_PARITY_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, enable;
    logic [7:0] status, rd_data;
    logic       status_valid, rd_valid, wr_req, end_req;
    logic [7:0] cmd, wr_data;
    logic       cmd_valid, rd_ready, wr_valid, stop, busy, parity_err;
    logic [7:0] cmd0, wr_data0;
    logic       cmd_valid0, rd_ready0, wr_valid0, stop0, busy0, parity_err0;

    int tests = 0;
    int fails = 0;

    cu_channel_responder_if ch();
    cu_channel_responder_if ch0();

    assign ch0.bus_out         = ch.bus_out;
    assign ch0.bus_out_parity  = ch.bus_out_parity;
    assign ch0.operational_out = ch.operational_out;
    assign ch0.select_out      = ch.select_out;
    assign ch0.hold_out        = ch.hold_out;
    assign ch0.address_out     = ch.address_out;
    assign ch0.command_out     = ch.command_out;
    assign ch0.service_out     = ch.service_out;

    cu_channel_responder #(.DEV_ADDR(DEV), .PASS_SELECT(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ch(ch.slave),
        .cmd(cmd), .cmd_valid(cmd_valid), .status(status), .status_valid(status_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_req(wr_req), .wr_data(wr_data), .wr_valid(wr_valid),
        .end_req(end_req), .stop(stop), .busy(busy), .parity_err(parity_err)
    );

    cu_channel_responder #(.DEV_ADDR(DEV), .PASS_SELECT(1'b0)) u_dut_nopass (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ch(ch0.slave),
        .cmd(cmd0), .cmd_valid(cmd_valid0), .status(status), .status_valid(status_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready0),
        .wr_req(wr_req), .wr_data(wr_data0), .wr_valid(wr_valid0),
        .end_req(end_req), .stop(stop0), .busy(busy0), .parity_err(parity_err0)
    );

    // Reference rules: odd parity by counting ones, address decode by compare.
    function automatic logic odd_par(input logic [7:0] b);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) if (b[i]) n++;
        return (n % 2) == 0;
    endfunction

    function automatic logic addressed(input logic [7:0] a);
        return a == DEV;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus(input logic [7:0] b);
        ch.bus_out        = b;
        ch.bus_out_parity = odd_par(b);
    endtask

    task automatic chan_quiet();
        ch.operational_out = 1'b1;
        ch.select_out      = 1'b0;
        ch.hold_out        = 1'b0;
        ch.address_out     = 1'b0;
        ch.command_out     = 1'b0;
        ch.service_out     = 1'b0;
        drive_bus(8'h00);
    endtask

    task automatic dev_quiet();
        status = 8'h00; status_valid = 1'b0;
        rd_data = 8'h00; rd_valid = 1'b0;
        wr_req = 1'b0; end_req = 1'b0;
    endtask

    task automatic abort_link();
        ch.operational_out = 1'b0;
        ch.select_out = 1'b0; ch.address_out = 1'b0;
        ch.command_out = 1'b0; ch.service_out = 1'b0;
        dev_quiet();
        step();
        chan_quiet();
        step();
    endtask

    task automatic select_and_command(input logic [7:0] c);
        chan_quiet(); dev_quiet();
        ch.select_out = 1'b1; ch.address_out = 1'b1; drive_bus(DEV);
        step();
        ch.address_out = 1'b0; ch.command_out = 1'b1; drive_bus(c);
        step();
    endtask

    task automatic present_status(input logic [7:0] s);
        ch.command_out = 1'b0; drive_bus(8'h00);
        status_valid = 1'b1; status = s;
        step();
        status_valid = 1'b0;
    endtask

    task automatic open_to_data(input logic [7:0] c, input logic [7:0] s);
        select_and_command(c);
        present_status(s);
        ch.service_out = 1'b1; step();
        ch.service_out = 1'b0; step();
    endtask

    task automatic test_reset();
        logic [36:0] outs;
        outs = {ch.bus_in, ch.bus_in_parity, ch.operational_in, ch.select_in, ch.address_in,
                ch.status_in, ch.service_in, ch.request_in, cmd, cmd_valid, rd_ready,
                wr_data, wr_valid, stop, busy, parity_err};
        tests++; if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    endtask

    task automatic test_read();
        logic [7:0] rb, st;
        rb = 8'($urandom); st = 8'($urandom) & 8'hF7;
        chan_quiet(); dev_quiet();
        ch.select_out = 1'b1; ch.address_out = 1'b1; drive_bus(DEV); step();
        tests++; if ({ch.operational_in, ch.address_in, ch.bus_in, busy} !== {1'b1, 1'b1, DEV, 1'b1}) begin
            fails++; $display("FAIL rd_select: got %b%b %h %b want 11 %h 1", ch.operational_in, ch.address_in, ch.bus_in, busy, DEV); end
        tests++; if (ch.bus_in_parity !== odd_par(DEV)) begin
            fails++; $display("FAIL rd_addr_parity: got %b want %b", ch.bus_in_parity, odd_par(DEV)); end
        ch.address_out = 1'b0; ch.command_out = 1'b1; drive_bus(8'h02); step();
        tests++; if ({cmd_valid, cmd, ch.address_in, ch.bus_in} !== {1'b1, 8'h02, 1'b0, 8'h00}) begin
            fails++; $display("FAIL rd_cmd: got %b %h %b %h want 1 02 0 00", cmd_valid, cmd, ch.address_in, ch.bus_in); end
        present_status(st);
        tests++; if ({ch.status_in, ch.bus_in, cmd_valid} !== {1'b1, st, 1'b0}) begin
            fails++; $display("FAIL rd_istat: got %b %h %b want 1 %h 0", ch.status_in, ch.bus_in, cmd_valid, st); end
        ch.service_out = 1'b1; step();
        tests++; if (ch.status_in !== 1'b0) begin fails++; $display("FAIL rd_istat_drop: got %b want 0", ch.status_in); end
        ch.service_out = 1'b0; rd_valid = 1'b1; rd_data = rb; step();
        tests++; if ({ch.service_in, rd_ready} !== 2'b00) begin
            fails++; $display("FAIL rd_outw_wait: got %b%b want 00", ch.service_in, rd_ready); end
        step();
        tests++; if ({ch.service_in, rd_ready, ch.bus_in, ch.bus_in_parity} !== {1'b1, 1'b1, rb, odd_par(rb)}) begin
            fails++; $display("FAIL rd_byte: got %b%b %h %b want 11 %h %b", ch.service_in, rd_ready, ch.bus_in, ch.bus_in_parity, rb, odd_par(rb)); end
        rd_valid = 1'b0; ch.service_out = 1'b1; step();
        tests++; if ({ch.service_in, ch.bus_in, wr_valid, rd_ready} !== 11'h0) begin
            fails++; $display("FAIL rd_svc_ack: got %b %h %b %b want 0 00 0 0", ch.service_in, ch.bus_in, wr_valid, rd_ready); end
        ch.service_out = 1'b0; step();
        end_req = 1'b1; status_valid = 1'b1; status = 8'h0C; step();
        tests++; if ({ch.status_in, ch.bus_in} !== {1'b1, 8'h0C}) begin
            fails++; $display("FAIL rd_estat: got %b %h want 1 0c", ch.status_in, ch.bus_in); end
        end_req = 1'b0; status_valid = 1'b0; ch.service_out = 1'b1; step();
        tests++; if (ch.status_in !== 1'b0) begin fails++; $display("FAIL rd_estat_drop: got %b want 0", ch.status_in); end
        ch.service_out = 1'b0; step();
        tests++; if (ch.operational_in !== 1'b1) begin fails++; $display("FAIL rd_disc_hold: got %b want 1", ch.operational_in); end
        step();
        tests++; if ({ch.operational_in, busy, ch.bus_in} !== 10'h0) begin
            fails++; $display("FAIL rd_disc: got %b %b %h want 0 0 00", ch.operational_in, busy, ch.bus_in); end
        chan_quiet(); step();
    endtask

    task automatic test_select_random();
        logic [7:0] a;
        logic       m;
        for (int k = 0; k < 6; k++) begin
            a = ($urandom_range(0, 1) == 1) ? DEV : 8'($urandom);
            m = addressed(a);
            chan_quiet(); dev_quiet();
            ch.select_out = 1'b1; ch.address_out = 1'b1; drive_bus(a); step();
            tests++; if ({ch.operational_in, ch.address_in, ch.select_in, busy} !== {m, m, ~m, 1'b1}) begin
                fails++; $display("FAIL sel_rand addr=%h: got %b%b%b%b want %b%b%b1", a, ch.operational_in, ch.address_in, ch.select_in, busy, m, m, ~m); end
            abort_link();
            tests++; if ({ch.operational_in, ch.address_in, ch.select_in, busy} !== 4'b0000) begin
                fails++; $display("FAIL sel_rand_abort: got %b%b%b%b want 0000", ch.operational_in, ch.address_in, ch.select_in, busy); end
        end
    endtask

    task automatic test_pass();
        chan_quiet(); dev_quiet();
        ch.select_out = 1'b1; ch.address_out = 1'b1; drive_bus(8'h0F); step();
        tests++; if ({ch.operational_in, ch.select_in, busy, ch0.select_in} !== 4'b0110) begin
            fails++; $display("FAIL pass_enter: got %b%b%b%b want 0110", ch.operational_in, ch.select_in, busy, ch0.select_in); end
        drive_bus(DEV); step();
        tests++; if ({ch.operational_in, ch.address_in, ch.select_in} !== 3'b001) begin
            fails++; $display("FAIL pass_ignore_match: got %b%b%b want 001", ch.operational_in, ch.address_in, ch.select_in); end
        ch.select_out = 1'b0; ch.address_out = 1'b0; step();
        tests++; if ({ch.select_in, busy, ch0.select_in} !== 3'b000) begin
            fails++; $display("FAIL pass_leave: got %b%b%b want 000", ch.select_in, busy, ch0.select_in); end
        chan_quiet(); step();
    endtask

    task automatic test_write_stop();
        logic [7:0] wb;
        wb = 8'($urandom);
        open_to_data(8'h01, 8'h00);
        wr_req = 1'b1; step();
        tests++; if ({ch.service_in, ch.bus_in} !== {1'b1, 8'h00}) begin
            fails++; $display("FAIL wr_svc_in: got %b %h want 1 00", ch.service_in, ch.bus_in); end
        wr_req = 1'b0; drive_bus(wb); ch.service_out = 1'b1; step();
        tests++; if ({wr_valid, wr_data, ch.service_in} !== {1'b1, wb, 1'b0}) begin
            fails++; $display("FAIL wr_latch: got %b %h %b want 1 %h 0", wr_valid, wr_data, ch.service_in, wb); end
        ch.service_out = 1'b0; drive_bus(8'h00); step();
        tests++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL wr_pulse_len: got %b want 0", wr_valid); end
        wr_req = 1'b1; step();
        wr_req = 1'b0; ch.command_out = 1'b1; ch.service_out = 1'b1; step();
        tests++; if ({stop, ch.service_in, wr_valid} !== 3'b100) begin
            fails++; $display("FAIL wr_stop: got %b%b%b want 100", stop, ch.service_in, wr_valid); end
        ch.command_out = 1'b0; ch.service_out = 1'b0; step();
        step();
        tests++; if ({stop, busy} !== 2'b01) begin fails++; $display("FAIL wr_stop_after: got %b%b want 01", stop, busy); end
        abort_link();
    endtask

    task automatic test_data_random();
        logic [7:0] exp_q[$];
        logic [7:0] b, es, e;
        open_to_data(8'($urandom), 8'($urandom) & 8'hF7);
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            if ($urandom_range(0, 1) == 0) begin
                rd_valid = 1'b1; rd_data = b; step();
                e = exp_q.pop_front();
                tests++; if ({ch.service_in, rd_ready, ch.bus_in} !== {1'b1, 1'b1, e}) begin
                    fails++; $display("FAIL dr_read%0d: got %b%b %h want 11 %h", k, ch.service_in, rd_ready, ch.bus_in, e); end
                rd_valid = 1'b0; ch.service_out = 1'b1; step();
            end else begin
                wr_req = 1'b1; step();
                wr_req = 1'b0; drive_bus(b); ch.service_out = 1'b1; step();
                e = exp_q.pop_front();
                tests++; if ({wr_valid, wr_data, rd_ready} !== {1'b1, e, 1'b0}) begin
                    fails++; $display("FAIL dr_write%0d: got %b %h %b want 1 %h 0", k, wr_valid, wr_data, rd_ready, e); end
            end
            ch.service_out = 1'b0; drive_bus(8'h00); step();
        end
        es = 8'($urandom);
        end_req = 1'b1; rd_valid = 1'b1; wr_req = 1'b1; step();
        tests++; if ({ch.status_in, ch.service_in, rd_ready} !== 3'b000) begin
            fails++; $display("FAIL dr_end_wait: got %b%b%b want 000", ch.status_in, ch.service_in, rd_ready); end
        status_valid = 1'b1; status = es; step();
        tests++; if ({ch.status_in, ch.service_in, rd_ready, ch.bus_in} !== {3'b100, es}) begin
            fails++; $display("FAIL dr_end_prio: got %b%b%b %h want 100 %h", ch.status_in, ch.service_in, rd_ready, ch.bus_in, es); end
        dev_quiet(); ch.command_out = 1'b1; step();
        ch.command_out = 1'b0; step(); step();
        tests++; if ({ch.operational_in, ch.status_in, busy} !== 3'b000) begin
            fails++; $display("FAIL dr_end_disc: got %b%b%b want 000", ch.operational_in, ch.status_in, busy); end
        chan_quiet(); step();
    endtask

    task automatic test_end_direct();
        open_to_data(8'h04, 8'h0C);
        tests++; if ({ch.operational_in, ch.service_in} !== 2'b10) begin
            fails++; $display("FAIL ce_disc_state: got %b%b want 10", ch.operational_in, ch.service_in); end
        rd_valid = 1'b1; step();
        tests++; if ({ch.operational_in, busy, ch.service_in, rd_ready} !== 4'b0000) begin
            fails++; $display("FAIL ce_no_data: got %b%b%b%b want 0000", ch.operational_in, busy, ch.service_in, rd_ready); end
        step();
        tests++; if (ch.request_in !== 1'b1) begin fails++; $display("FAIL ce_request_in: got %b want 1", ch.request_in); end
        rd_valid = 1'b0; step();
        tests++; if (ch.request_in !== 1'b0) begin fails++; $display("FAIL ce_request_drop: got %b want 0", ch.request_in); end
        chan_quiet(); step();
    endtask

    task automatic test_stack();
        select_and_command(8'($urandom));
        present_status(8'($urandom) & 8'hF7);
        ch.command_out = 1'b1; ch.service_out = 1'b1; step();
        tests++; if ({ch.status_in, ch.operational_in} !== 2'b01) begin
            fails++; $display("FAIL stk_drop: got %b%b want 01", ch.status_in, ch.operational_in); end
        ch.command_out = 1'b0; ch.service_out = 1'b0; step(); step();
        tests++; if ({ch.operational_in, busy, ch.service_in} !== 3'b000) begin
            fails++; $display("FAIL stk_disc: got %b%b%b want 000", ch.operational_in, busy, ch.service_in); end
        chan_quiet(); step();
    endtask

    task automatic test_enable();
        chan_quiet(); dev_quiet();
        enable = 1'b0; ch.select_out = 1'b1; ch.address_out = 1'b1; drive_bus(DEV); step();
        tests++; if ({ch.operational_in, ch.select_in, ch0.select_in, busy} !== 4'b0110) begin
            fails++; $display("FAIL en_off: got %b%b%b%b want 0110", ch.operational_in, ch.select_in, ch0.select_in, busy); end
        ch.select_out = 1'b0; step();
        tests++; if ({ch.select_in, ch0.select_in} !== 2'b00) begin
            fails++; $display("FAIL en_off_sel_drop: got %b%b want 00", ch.select_in, ch0.select_in); end
        enable = 1'b1; chan_quiet(); step();
    endtask

    task automatic test_parity();
        select_and_command(8'h00);
        abort_link();
        chan_quiet();
        ch.select_out = 1'b1; ch.address_out = 1'b1; drive_bus(DEV); step();
        ch.address_out = 1'b0; ch.command_out = 1'b1;
        ch.bus_out = 8'h03; ch.bus_out_parity = ~odd_par(8'h03); step();
        tests++; if ({cmd_valid, cmd, parity_err} !== {1'b1, 8'h03, PERR_EXP}) begin
            fails++; $display("FAIL par_cmd: got %b %h %b want 1 03 %b", cmd_valid, cmd, parity_err, PERR_EXP); end
        ch.command_out = 1'b0; drive_bus(8'h00); step(); step();
        tests++; if (parity_err !== PERR_EXP) begin fails++; $display("FAIL par_sticky: got %b want %b", parity_err, PERR_EXP); end
        abort_link();
    endtask

    task automatic test_abort_reset();
        logic [36:0] outs;
        logic [7:0]  es;
        open_to_data(8'h01, 8'h00);
        wr_req = 1'b1; step();
        wr_req = 1'b0; ch.operational_out = 1'b0; ch.service_out = 1'b1; drive_bus(8'hAA); step();
        tests++; if ({ch.operational_in, ch.service_in, wr_valid, busy, ch.bus_in} !== 12'h0) begin
            fails++; $display("FAIL abort_svc: got %b%b%b%b %h want 0000 00", ch.operational_in, ch.service_in, wr_valid, busy, ch.bus_in); end
        chan_quiet(); step();
        es = 8'($urandom);
        open_to_data(8'h02, 8'h00);
        end_req = 1'b1; status_valid = 1'b1; status = es; step();
        tests++; if ({ch.status_in, ch.bus_in} !== {1'b1, es}) begin
            fails++; $display("FAIL rst_estat: got %b %h want 1 %h", ch.status_in, ch.bus_in, es); end
        #2 reset_n = 1'b0;
        #1;
        outs = {ch.bus_in, ch.bus_in_parity, ch.operational_in, ch.select_in, ch.address_in,
                ch.status_in, ch.service_in, ch.request_in, cmd, cmd_valid, rd_ready,
                wr_data, wr_valid, stop, busy, parity_err};
        tests++; if (outs !== '0) begin fails++; $display("FAIL rst_async: got %h want 0", outs); end
        dev_quiet(); chan_quiet(); step();
        reset_n = 1'b1; step(); step();
        tests++; if (ch.bus_in_parity !== odd_par(ch.bus_in)) begin
            fails++; $display("FAIL rst_parity_idle: got %b want %b", ch.bus_in_parity, odd_par(ch.bus_in)); end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1;
        chan_quiet(); dev_quiet();
        repeat (3) step();
        test_reset();
        reset_n = 1'b1; step(); step();
        test_read();
        test_select_random();
        test_pass();
        test_write_stop();
        test_data_random();
        test_end_direct();
        test_stack();
        test_enable();
        test_parity();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
